// File: rtl/bus_xfer_ctrl.sv
// Break-before-make sequencer for the CPU/RAM 8-bit bus transceiver.
// Handles turnaround on direction change, RAM strobes, and the CPU req/ack handshake.
module bus_xfer_ctrl #(
    parameter int TURN_CYCLES   = 1,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ack,
    output logic       busy,
    output logic       bus_oe_n,
    output logic       bus_dir,
    output logic       bus_drive,
    input  logic [7:0] bus_din,
    output logic       mem_ce_n,
    output logic       mem_we_n
);

    // Handshake: req is a level held stable with we/wdata until the one-cycle
    // ack pulse; a req still high when the transfer finishes starts a new one.
    typedef enum logic [1:0] {IDLE, TURN, ACCESS, RECOVER} state_t;

    localparam logic [3:0] T_LAST = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] A_LAST = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] A_HOLD = 4'(ACCESS_CYCLES - 2);

    state_t     state;
    logic [3:0] cnt;
    logic       we_q;

    // Write data is driven externally under bus_drive; it never enters this block.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            rdata     <= 8'h00;
            ack       <= 1'b0;
            busy      <= 1'b0;
            bus_oe_n  <= 1'b1;
            bus_dir   <= 1'b0;
            bus_drive <= 1'b0;
            mem_ce_n  <= 1'b1;
            mem_we_n  <= 1'b1;
        end else begin
            case (state)
                // The edge leaving RECOVER samples req exactly like IDLE does,
                // so a held req yields back-to-back transfers.
                IDLE, RECOVER: begin
                    ack <= 1'b0;
                    if (req) begin
                        we_q <= we;
                        busy <= 1'b1;
                        cnt  <= 4'd0;
                        if (we != bus_dir) begin
                            bus_dir <= we;
                            state   <= TURN;
                        end else begin
                            state     <= ACCESS;
                            bus_oe_n  <= 1'b0;
                            mem_ce_n  <= 1'b0;
                            bus_drive <= we;
                            mem_we_n  <= ~we;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                TURN: begin
                    if (cnt == T_LAST) begin
                        state     <= ACCESS;
                        cnt       <= 4'd0;
                        bus_oe_n  <= 1'b0;
                        mem_ce_n  <= 1'b0;
                        bus_drive <= we_q;
                        mem_we_n  <= ~we_q;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ACCESS: begin
                    if (cnt == A_LAST) begin
                        state     <= RECOVER;
                        cnt       <= 4'd0;
                        bus_oe_n  <= 1'b1;
                        mem_ce_n  <= 1'b1;
                        bus_drive <= 1'b0;
                        mem_we_n  <= 1'b1;
                        ack       <= 1'b1;
                        if (!we_q) rdata <= bus_din;
                    end else begin
                        cnt <= cnt + 4'd1;
                        // Release the write stroke one cycle early to hold data.
                        if (cnt == A_HOLD) mem_we_n <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: vector table, hand sequences, and random traffic
// checked cycle by cycle against a transaction-level expected-waveform queue.
module tb_bus_xfer_ctrl;

    localparam int TC = 1;
    localparam int AC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req = 1'b0, we = 1'b0, req2 = 1'b0, we2 = 1'b0;
    logic [7:0] wdata = 8'h00, wdata2 = 8'h00, bus_din = 8'h00;
    logic [7:0] rdata, rdata2;
    logic       ack, busy, bus_oe_n, bus_dir, bus_drive, mem_ce_n, mem_we_n;
    logic       ack2, busy2, oe_n2, dir2, drive2, ce_n2, we_n2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bus_xfer_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy), .bus_oe_n(bus_oe_n),
        .bus_dir(bus_dir), .bus_drive(bus_drive), .bus_din(bus_din),
        .mem_ce_n(mem_ce_n), .mem_we_n(mem_we_n)
    );

    bus_xfer_ctrl #(.TURN_CYCLES(3), .ACCESS_CYCLES(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .we(we2), .wdata(wdata2),
        .rdata(rdata2), .ack(ack2), .busy(busy2), .bus_oe_n(oe_n2),
        .bus_dir(dir2), .bus_drive(drive2), .bus_din(bus_din),
        .mem_ce_n(ce_n2), .mem_we_n(we_n2)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model (default-parameter DUT) ----------------
    typedef struct packed {
        logic ack; logic busy; logic oe_n; logic dir;
        logic drive; logic ce_n; logic we_n; logic cap;
    } cyc_t;

    logic [7:0] exp_q[$];
    logic       m_dir = 1'b0;
    logic [7:0] m_rdata = 8'h00;

    // Each accepted request expands into its full expected waveform:
    // TC turn cycles if the direction flips, AC access cycles, one recover cycle.
    always @(posedge clk or negedge rst_n) begin
        cyc_t c;
        if (!rst_n) begin
            exp_q.delete();
            m_dir = 1'b0;
            m_rdata = 8'h00;
        end else begin
            if (exp_q.size() != 0) begin
                c = exp_q.pop_front();
                if (c.cap) m_rdata = bus_din;
            end
            if (exp_q.size() == 0 && req) begin
                if (we != m_dir)
                    for (int i = 0; i < TC; i++) begin
                        c = '{1'b0, 1'b1, 1'b1, we, 1'b0, 1'b1, 1'b1, 1'b0};
                        exp_q.push_back(c);
                    end
                m_dir = we;
                for (int i = 0; i < AC; i++) begin
                    c = '{1'b0, 1'b1, 1'b0, we, we, 1'b0,
                          (we ? (i == AC - 1) : 1'b1), (!we && i == AC - 1)};
                    exp_q.push_back(c);
                end
                c = '{1'b1, 1'b1, 1'b1, we, 1'b0, 1'b1, 1'b1, 1'b0};
                exp_q.push_back(c);
            end
        end
    end

    // ---------------- scoreboard + invariants ----------------
    logic prev_dir = 1'b0, prev_oe = 1'b1, prev_dir2 = 1'b0, prev_oe2 = 1'b1;

    always @(negedge clk) begin
        cyc_t e;
        if (rst_n === 1'b1) begin
            if (exp_q.size() != 0) e = cyc_t'(exp_q[0]);
            else e = '{1'b0, 1'b0, 1'b1, m_dir, 1'b0, 1'b1, 1'b1, 1'b0};
            chk("cycle_outputs",
                {17'd0, ack, busy, bus_oe_n, bus_dir, bus_drive, mem_ce_n, mem_we_n, rdata},
                {17'd0, e.ack, e.busy, e.oe_n, e.dir, e.drive, e.ce_n, e.we_n, m_rdata});
            chk("inv_drive", 32'(bus_drive && !(bus_dir && !bus_oe_n)), 0);
            chk("inv_drive2", 32'(drive2 && !(dir2 && !oe_n2)), 0);
            if (prev_dir !== bus_dir) chk("dir_change_enabled", 32'(prev_oe & bus_oe_n), 1);
            if (prev_dir2 !== dir2) chk("dir_change_enabled2", 32'(prev_oe2 & oe_n2), 1);
        end
        prev_dir = bus_dir; prev_oe = bus_oe_n;
        prev_dir2 = dir2;   prev_oe2 = oe_n2;
    end

    // ---------------- driver ----------------
    task automatic xfer(input bit sel, input logic w, input logic [7:0] d, input logic [7:0] din,
                        output int lat, output int oe_hi, output int oe_lo,
                        output int we_lo, output int drv);
        lat = -1; oe_hi = 0; oe_lo = 0; we_lo = 0; drv = 0;
        @(posedge clk); #1;
        if (sel) begin req2 = 1'b1; we2 = w; wdata2 = d; end
        else begin req = 1'b1; we = w; wdata = d; end
        bus_din = din;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((sel ? ack2 : ack) === 1'b1) begin
                lat = k;
                break;
            end
            if ((sel ? oe_n2 : bus_oe_n) === 1'b1) oe_hi++; else oe_lo++;
            if ((sel ? we_n2 : mem_we_n) === 1'b0) we_lo++;
            if ((sel ? drive2 : bus_drive) === 1'b1) drv++;
        end
        req = 1'b0;
        req2 = 1'b0;
        if (lat < 0) chk("ack_timeout", 0, 1);
    endtask

    typedef struct {
        logic w; logic [7:0] d; logic [7:0] din; logic [7:0] exp_rdata; int exp_lat;
    } vec_t;

    vec_t tbl[6];
    int lat, oe_hi, oe_lo, we_lo, drv;
    int first_ack, second_ack;
    logic dir_ok, saw_ack;

    initial begin
        tbl[0] = '{1'b0, 8'h00, 8'hA5, 8'hA5, 2};  // read, no turn after reset
        tbl[1] = '{1'b1, 8'h3C, 8'h00, 8'hA5, 3};  // write after read: turn
        tbl[2] = '{1'b1, 8'hC3, 8'h11, 8'hA5, 2};  // same-direction write
        tbl[3] = '{1'b0, 8'h00, 8'h5A, 8'h5A, 3};  // read after write: turn
        tbl[4] = '{1'b0, 8'h00, 8'h0F, 8'h0F, 2};
        tbl[5] = '{1'b1, 8'h77, 8'hEE, 8'h0F, 3};

        // Reset asserted mid-cycle takes effect immediately
        #1 rst_n = 1'b0;
        #1;
        chk("rst_oe_n", bus_oe_n, 1);
        chk("rst_dir", bus_dir, 0);
        chk("rst_we_n", mem_we_n, 1);
        chk("rst_ce_n", mem_ce_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_drive", bus_drive, 0);
        chk("rst_rdata", rdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        foreach (tbl[i]) begin
            xfer(1'b0, tbl[i].w, tbl[i].d, tbl[i].din, lat, oe_hi, oe_lo, we_lo, drv);
            chk("vec_latency", lat, tbl[i].exp_lat);
            chk("vec_rdata", rdata, tbl[i].exp_rdata);
            chk("vec_oe_low", oe_lo, AC);
            chk("vec_oe_high", oe_hi, tbl[i].exp_lat - AC);
            chk("vec_we_low", we_lo, tbl[i].w ? AC - 1 : 0);
            chk("vec_drive", drv, tbl[i].w ? AC : 0);
            chk("vec_dir", bus_dir, tbl[i].w);
        end

        // Back-to-back writes with req held across ack
        first_ack = -1; second_ack = -1; dir_ok = 1'b1;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; wdata = 8'hA1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus_dir !== 1'b1) dir_ok = 1'b0;
            if (ack === 1'b1) begin
                if (first_ack < 0) first_ack = cyc;
                else begin
                    second_ack = cyc;
                    break;
                end
            end
        end
        req = 1'b0;
        chk("b2b_gap", second_ack - first_ack, 3);
        chk("b2b_dir", dir_ok, 1);
        chk("b2b_rdata", rdata, 8'h0F);

        // Reset during the first ACCESS cycle of a write
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; wdata = 8'hE7;
        @(posedge clk); #3;
        chk("mid_write_we_n", mem_we_n, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_we_n", mem_we_n, 1);
        chk("abort_ce_n", mem_ce_n, 1);
        chk("abort_oe_n", bus_oe_n, 1);
        chk("abort_drive", bus_drive, 0);
        chk("abort_ack", ack, 0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        saw_ack = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack === 1'b1) saw_ack = 1'b1;
        end
        chk("abort_no_ack", saw_ack, 0);
        chk("abort_idle", busy, 0);

        // Random traffic, including we/wdata churn while busy
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            req = ($urandom_range(0, 3) != 0);
            we = 1'($urandom_range(0, 1));
            wdata = 8'($urandom_range(0, 255));
            bus_din = 8'($urandom_range(0, 255));
        end
        req = 1'b0;
        repeat (8) @(negedge clk);

        // Long turn/access instance: write then read
        xfer(1'b1, 1'b1, 8'h81, 8'h00, lat, oe_hi, oe_lo, we_lo, drv);
        chk("p_wr_latency", lat, 7);
        chk("p_wr_we_low", we_lo, 3);
        chk("p_wr_drive", drv, 4);
        xfer(1'b1, 1'b0, 8'h00, 8'h6E, lat, oe_hi, oe_lo, we_lo, drv);
        chk("p_rd_latency", lat, 7);
        chk("p_rd_oe_high", oe_hi, 3);
        chk("p_rd_oe_low", oe_lo, 4);
        chk("p_rd_rdata", rdata2, 8'h6E);
        chk("p_rd_dir", dir2, 0);
        xfer(1'b1, 1'b0, 8'h00, 8'h19, lat, oe_hi, oe_lo, we_lo, drv);
        chk("p_rd2_latency", lat, 4);
        chk("p_rd2_rdata", rdata2, 8'h19);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
